// File: rtl/alu_pkg.sv
// Shared op-code constants and controller state encoding for the ALU subsystem.
package alu_pkg;

  localparam logic [3:0] OP_SUB   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_SHR   = 4'h7;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_SLT   = 4'h9;
  localparam logic [3:0] OP_SLTU  = 4'ha;
  localparam logic [3:0] OP_PASSA = 4'hb;
  localparam logic [3:0] OP_PASSB = 4'hc;
  localparam logic [3:0] OP_INC   = 4'hd;
  localparam logic [3:0] OP_DEC   = 4'he;
  localparam logic [3:0] OP_CLR   = 4'hf;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

endpackage

// File: rtl/alu.sv
// Reference ALU with registered operands; result and flag (result non-zero)
// are valid the cycle after the operands are presented.
module alu
  import alu_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            op,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  output logic [data_width-1:0] r,
  output logic                  flag
);

  localparam int SH_W = $clog2(data_width);
  localparam logic [data_width-1:0] ONE = data_width'(1);

  logic [data_width-1:0] a_q, b_q;
  logic [3:0]            op_q;
  logic [SH_W-1:0]       sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_CLR;
    end else begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
  end

  assign sh = b_q[SH_W-1:0];

  always_comb begin
    r = '0;
    case (op_q)
      OP_SUB:   r = a_q - b_q;
      OP_ADD:   r = a_q + b_q;
      OP_AND:   r = a_q & b_q;
      OP_OR:    r = a_q | b_q;
      OP_XOR:   r = a_q ^ b_q;
      OP_NOT:   r = ~a_q;
      OP_SHL:   r = a_q << sh;
      OP_SHR:   r = a_q >> sh;
      OP_SRA:   r = $unsigned($signed(a_q) >>> sh);
      OP_SLT:   r = ($signed(a_q) < $signed(b_q)) ? ONE : '0;
      OP_SLTU:  r = (a_q < b_q) ? ONE : '0;
      OP_PASSA: r = a_q;
      OP_PASSB: r = b_q;
      OP_INC:   r = a_q + ONE;
      OP_DEC:   r = a_q - ONE;
      default:  r = '0;
    endcase
  end

  assign flag = |r;

endmodule

// File: rtl/alu_sys.sv
// System wrapper: controller driving the reference ALU, for end-to-end tests.
module alu_sys
  import alu_pkg::*;
#(
  parameter int data_width = 32,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [data_width-1:0] cmd_a,
  input  logic [data_width-1:0] cmd_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_r,
  output logic                  rsp_flag,
  output logic [3:0]            rsp_op,
  output logic                  busy,
  output logic [cnt_width-1:0]  op_count,
  output logic [cnt_width-1:0]  flag_count
);

  logic [data_width-1:0] alu_a, alu_b, alu_r;
  logic [3:0]            alu_op;
  logic                  alu_flag;

  alu_ctrl #(.data_width(data_width), .cnt_width(cnt_width)) u_ctrl (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_A(alu_a), .alu_B(alu_b), .alu_op(alu_op),
    .alu_R(alu_r), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_flag(rsp_flag), .rsp_op(rsp_op),
    .busy(busy), .op_count(op_count), .flag_count(flag_count)
  );

  alu #(.data_width(data_width)) u_alu (
    .clk(clk), .rst_n(rst_n),
    .op(alu_op), .a(alu_a), .b(alu_b),
    .r(alu_r), .flag(alu_flag)
  );

endmodule

// File: rtl/alu_ctrl.sv
// Command/response sequencer for an external registered ALU: one op in flight,
// result captured and held until the consumer takes it, plus status counters.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int data_width = 32,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [data_width-1:0] cmd_a,
  input  logic [data_width-1:0] cmd_b,
  output logic [data_width-1:0] alu_A,
  output logic [data_width-1:0] alu_B,
  output logic [3:0]            alu_op,
  input  logic [data_width-1:0] alu_R,
  input  logic                  alu_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_r,
  output logic                  rsp_flag,
  output logic [3:0]            rsp_op,
  output logic                  busy,
  output logic [cnt_width-1:0]  op_count,
  output logic [cnt_width-1:0]  flag_count
);

  localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);

  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Reset asserts asynchronously but releases two clocks later, cleanly on an edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  logic [1:0] state_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= ST_IDLE;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_op     <= OP_CLR;
      rsp_r      <= '0;
      rsp_flag   <= 1'b0;
      rsp_op     <= OP_CLR;
      op_count   <= '0;
      flag_count <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_op  <= cmd_op;
            alu_A   <= cmd_a;
            alu_B   <= cmd_b;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          rsp_r    <= alu_R;
          rsp_flag <= alu_flag;
          rsp_op   <= alu_op;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          // Handshake: retire the op and park the ALU on the clear op code.
          if (rsp_ready) begin
            alu_op   <= OP_CLR;
            op_count <= op_count + CNT_ONE;
            if (rsp_flag) flag_count <= sat_inc(flag_count);
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized bench for alu_ctrl (with a bench-side ALU) and the alu_sys wrapper.
module tb_alu_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [3:0]    cmd_op = 4'h0;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] alu_R = '0;
  logic          alu_flag = 1'b0;

  logic          cmd_ready, rsp_valid, rsp_flag, busy;
  logic [DW-1:0] alu_A, alu_B, rsp_r;
  logic [3:0]    alu_op, rsp_op;
  logic [CW-1:0] op_count, flag_count;

  logic          s_cmd_ready, s_rsp_valid, s_rsp_flag, s_busy;
  logic [DW-1:0] s_rsp_r;
  logic [3:0]    s_rsp_op;
  logic [CW-1:0] s_op_count, s_flag_count;

  alu_ctrl #(.data_width(DW), .cnt_width(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_R(alu_R), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_flag(rsp_flag), .rsp_op(rsp_op),
    .busy(busy), .op_count(op_count), .flag_count(flag_count)
  );

  alu_sys #(.data_width(DW), .cnt_width(CW)) sys (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(s_rsp_r), .rsp_flag(s_rsp_flag), .rsp_op(s_rsp_op),
    .busy(s_busy), .op_count(s_op_count), .flag_count(s_flag_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    int unsigned sh;
    sh = b % DW;
    case (op)
      4'h0: return a - b;
      4'h1: return a + b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~a;
      4'h6: return a << sh;
      4'h7: return a >> sh;
      4'h8: return DW'($signed(a) >>> sh);
      4'h9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'ha: return (a < b) ? 32'd1 : 32'd0;
      4'hb: return a;
      4'hc: return b;
      4'hd: return a + 32'd1;
      4'he: return a - 32'd1;
      default: return '0;
    endcase
  endfunction

  // Bench-side ALU for the bare controller: registers operands, answers next cycle.
  always @(posedge clk) begin
    alu_R    <= ref_alu(alu_op, alu_A, alu_B);
    alu_flag <= (ref_alu(alu_op, alu_A, alu_B) != 0);
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int exp_ops = 0, exp_flags = 0;
  logic [DW-1:0] exp_r = '0;
  logic          exp_f = 1'b0;
  logic [3:0]    exp_op = 4'hf;
  int last_acc = -1;

  task automatic chk_rsp(input string tag);
    chk({tag, ".rsp_r"}, rsp_r, exp_r);
    chk({tag, ".rsp_flag"}, rsp_flag, exp_f);
    chk({tag, ".rsp_op"}, rsp_op, exp_op);
    chk({tag, ".sys_rsp_r"}, s_rsp_r, exp_r);
    chk({tag, ".sys_rsp_flag"}, s_rsp_flag, exp_f);
    chk({tag, ".sys_rsp_op"}, s_rsp_op, exp_op);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, ".op_count"}, op_count, exp_ops);
    chk({tag, ".flag_count"}, flag_count, exp_flags);
    chk({tag, ".sys_op_count"}, s_op_count, exp_ops);
    chk({tag, ".sys_flag_count"}, s_flag_count, exp_flags);
  endtask

  task automatic junk_cmd();
    cmd_valid = 1'b1;
    cmd_op = 4'($urandom_range(0, 15));
    cmd_a = $urandom;
    cmd_b = $urandom;
  endtask

  // Called at a negedge with the controller idle; returns at the negedge after the handshake.
  task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input int stall, input bit b2b);
    logic [DW-1:0] er;
    int lat;
    er = ref_alu(op, a, b);
    chk("idle.cmd_ready", {cmd_ready, s_cmd_ready}, 2'b11);
    if (b2b && last_acc >= 0) chk("accept_gap", cyc - last_acc, 4);
    last_acc = cyc;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    rsp_ready = (stall == 0);
    @(negedge clk);
    junk_cmd();
    chk("issue.alu_A", alu_A, a);
    chk("issue.alu_B", alu_B, b);
    chk("issue.alu_op", alu_op, op);
    chk("issue.busy_ready", {busy, cmd_ready, rsp_valid}, 3'b100);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      junk_cmd();
      lat++;
    end
    chk("latency", lat, 3);
    exp_r = er; exp_f = (er != 0); exp_op = op;
    for (int i = 0; i < stall; i++) begin
      chk_rsp("stall");
      chk("stall.valid_ready", {rsp_valid, s_rsp_valid, cmd_ready}, 3'b110);
      @(negedge clk);
      junk_cmd();
    end
    rsp_ready = 1'b1;
    chk_rsp("resp");
    chk("resp.valid", {rsp_valid, s_rsp_valid}, 2'b11);
    @(posedge clk);
    exp_ops = (exp_ops + 1) % (CNT_MAX + 1);
    if (exp_f && exp_flags < CNT_MAX) exp_flags++;
    @(negedge clk);
    chk("done.alu_op_clr", alu_op, 4'hf);
    chk("done.alu_A_held", alu_A, a);
    chk("done.valid_ready", {rsp_valid, s_rsp_valid, cmd_ready, busy}, 4'b0010);
    chk_rsp("done");
    chk_counts("done");
    if (!b2b) begin
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ctl"}, {cmd_ready, rsp_valid, busy, s_cmd_ready, s_rsp_valid, s_busy}, 6'b100100);
    chk({tag, ".alu_A"}, alu_A, 0);
    chk({tag, ".alu_B"}, alu_B, 0);
    chk({tag, ".alu_op"}, alu_op, 4'hf);
    chk_rsp(tag);
    chk_counts(tag);
  endtask

  initial begin
    logic [3:0]    op;
    logic [DW-1:0] a, b;

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_state("idle");

    run_op(4'h1, 32'd5, 32'd7, 0, 1'b0);
    chk("add.result", rsp_r, 32'd12);
    chk("add.counts", {op_count, flag_count}, {4'd1, 4'd1});

    run_op(4'h0, 32'd3, 32'd5, 4, 1'b0);
    chk("sub.result", {rsp_flag, rsp_r}, {1'b1, 32'hFFFF_FFFE});

    last_acc = -1;
    run_op(4'h2, 32'h0000_00F0, 32'h0000_000F, 0, 1'b1);
    run_op(4'h3, 32'h0, 32'h0, 0, 1'b1);
    run_op(4'h4, 32'h5, 32'h5, 0, 1'b1);
    run_op(4'h5, 32'hFFFF_FFFF, 32'h0, 0, 1'b1);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk("b2b.counts", {op_count, flag_count}, {4'd6, 4'd2});

    // Reset while the SHL op sits in CAPTURE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h6; cmd_a = 32'd1; cmd_b = 32'd4; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_ops = 0; exp_flags = 0; exp_r = '0; exp_f = 1'b0; exp_op = 4'hf;
    chk_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postreset.no_rsp", {rsp_valid, s_rsp_valid}, 2'b00);
    end
    chk_counts("postreset");

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 14));
      a = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(op, a, b, $urandom_range(0, 3), 1'b0);
    end
    chk("final.flag_sat", flag_count, exp_flags);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
